// File: rtl/checker_pkg.sv
// Shared types and constants for the memory-write scoreboard.
package checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam logic [7:0] ERR_UNARMED = 8'hFF;
  localparam logic [7:0] ERR_SAT     = 8'hFE;
  localparam logic [5:0] IDX_NONE    = 6'h3F;

  // Error counter add that sticks at ERR_SAT so it never reaches the unarmed code.
  function automatic logic [7:0] err_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, ERR_SAT}) ? ERR_SAT : s[7:0];
  endfunction

endpackage

// File: rtl/wr_edge_filter.sv
// Collapses a write held across stall cycles into a single accepted write.
module wr_edge_filter #(
  parameter int ADDR_W = 30
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wen_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              acc_o
);

  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      wen_q  <= wen_i;
      addr_q <= addr_i;
    end
  end

  assign acc_o = wen_i && (!wen_q || (addr_i != addr_q));

endmodule

// File: rtl/mem_write_checker.sv
// Bus-snooping write scoreboard: arms on a trigger write, checks a window of slots.
// Optional macro CHECKER_ORDER_EN adds an error for out-of-order slot writes.
//
// state     | meaning
// ST_IDLE   | unarmed, expected table writable, waiting for trigger write
// ST_CHECK  | armed, comparing window writes, counting duration
// ST_REPORT | results frozen, finish high until reset
module mem_write_checker
  import checker_pkg::*;
#(
  parameter int                ADDR_W    = 30,
  parameter int                DATA_W    = 32,
  parameter int                NUM_CHECK = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1,
  parameter logic [ADDR_W-1:0] TRIG_ADDR = 'h0,
  parameter logic [DATA_W-1:0] TRIG_DATA = 'h5,
  parameter logic [15:0]       TIMEOUT   = 16'd5000,
  localparam int               IDX_W     = (NUM_CHECK > 1) ? $clog2(NUM_CHECK) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              wen_i,
  input  logic              cfg_wen_i,
  input  logic [IDX_W-1:0]  cfg_idx_i,
  input  logic [DATA_W-1:0] cfg_data_i,
  output logic [7:0]        error_num_o,
  output logic [15:0]       duration_o,
  output logic              finish_o,
  output logic              timed_out_o,
  output logic [5:0]        first_err_idx_o
);

  state_e                 state_q, state_d;
  logic [7:0]             err_q, err_d;
  logic [15:0]            dur_q, dur_d;
  logic                   to_q, to_d;
  logic [5:0]             first_q, first_d;
  logic [NUM_CHECK-1:0]   hit_q, hit_d;
  logic [DATA_W-1:0]      exp_q [NUM_CHECK];

  logic                   acc;
  logic [ADDR_W-1:0]      off;
  logic                   in_win;
  logic [IDX_W-1:0]       slot;
  logic [7:0]             inc;
  logic [7:0]             miss_cnt;

  wr_edge_filter #(.ADDR_W(ADDR_W)) u_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wen_i  (wen_i),
    .addr_i (addr_i),
    .acc_o  (acc)
  );

  // Expected table deliberately survives reset so one load serves many runs.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_IDLE && cfg_wen_i && (int'(cfg_idx_i) < NUM_CHECK))
      exp_q[cfg_idx_i] <= cfg_data_i;
  end

  assign off    = addr_i - BASE_ADDR;
  assign in_win = (addr_i >= BASE_ADDR) && (off < ADDR_W'(NUM_CHECK));
  assign slot   = off[IDX_W-1:0];

`ifdef CHECKER_ORDER_EN
  logic [IDX_W-1:0] low_unhit;
  always_comb begin
    low_unhit = '0;
    for (int i = NUM_CHECK - 1; i >= 0; i--)
      if (!hit_q[i]) low_unhit = IDX_W'(i);
  end
`endif

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    dur_d    = dur_q;
    to_d     = to_q;
    first_d  = first_q;
    hit_d    = hit_q;
    inc      = 8'd0;
    miss_cnt = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (acc && addr_i == TRIG_ADDR && data_i == TRIG_DATA) begin
          state_d = ST_CHECK;
          err_d   = 8'd0;
          dur_d   = 16'd0;
          hit_d   = '0;
        end
      end
      ST_CHECK: begin
        if (dur_q != 16'hFFFF) dur_d = dur_q + 16'd1;
        if (acc && in_win) begin
          if (!hit_q[slot]) begin
            hit_d[slot] = 1'b1;
            if (data_i != exp_q[slot]) begin
              inc = inc + 8'd1;
              if (first_q == IDX_NONE) first_d = 6'(slot);
            end
`ifdef CHECKER_ORDER_EN
            if (slot != low_unhit) inc = inc + 8'd1;
`endif
          end else begin
            inc = 8'd1;
          end
        end
        err_d = err_add(err_q, inc);
        if (&hit_q) begin
          state_d = ST_REPORT;
        end else if (TIMEOUT != 16'd0 && dur_q == TIMEOUT - 16'd1) begin
          state_d = ST_REPORT;
          // A write that completes the window on the timeout cycle still counts as completion.
          if (!(&hit_d)) begin
            for (int i = 0; i < NUM_CHECK; i++)
              if (!hit_d[i]) miss_cnt = miss_cnt + 8'd1;
            to_d  = 1'b1;
            err_d = err_add(err_d, miss_cnt);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_UNARMED;
      dur_q   <= 16'd0;
      to_q    <= 1'b0;
      first_q <= IDX_NONE;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      dur_q   <= dur_d;
      to_q    <= to_d;
      first_q <= first_d;
      hit_q   <= hit_d;
    end
  end

  assign error_num_o     = err_q;
  assign duration_o      = dur_q;
  assign finish_o        = (state_q == ST_REPORT);
  assign timed_out_o     = to_q;
  assign first_err_idx_o = first_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker built with a 20-cycle timeout.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        cfg_wen;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_data;
  logic [7:0]  error_num;
  logic [15:0] duration;
  logic        finish;
  logic        timed_out;
  logic [5:0]  first_err_idx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_write_checker #(
    .ADDR_W(30), .DATA_W(32), .NUM_CHECK(4),
    .BASE_ADDR(30'h1), .TRIG_ADDR(30'h0), .TRIG_DATA(32'h5),
    .TIMEOUT(16'd20)
  ) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(data), .wen_i(wen),
    .cfg_wen_i(cfg_wen), .cfg_idx_i(cfg_idx), .cfg_data_i(cfg_data),
    .error_num_o(error_num), .duration_o(duration), .finish_o(finish),
    .timed_out_o(timed_out), .first_err_idx_o(first_err_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    wen = 1'b0;
    cfg_wen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    data = d;
    wen  = 1'b1;
    @(negedge clk);
    wen  = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] i, input logic [31:0] d);
    @(negedge clk);
    cfg_idx  = i;
    cfg_data = d;
    cfg_wen  = 1'b1;
    @(negedge clk);
    cfg_wen  = 1'b0;
  endtask

  task automatic wait_fin(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (finish === 1'b1) break;
      @(negedge clk);
    end
    check({tag, "_finish"}, 32'(finish), 32'd1);
  endtask

  initial begin
    rst = 1'b0; addr = '0; data = '0; wen = 1'b0;
    cfg_wen = 1'b0; cfg_idx = '0; cfg_data = '0;
    repeat (2) @(negedge clk);
    check("rst_err",   32'(error_num),     32'hFF);
    check("rst_dur",   32'(duration),      32'd0);
    check("rst_fin",   32'(finish),        32'd0);
    check("rst_to",    32'(timed_out),     32'd0);
    check("rst_first", 32'(first_err_idx), 32'h3F);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) cfg(2'(i), 32'd4);

    // clean run: completion one cycle after last write, 9 CHECK cycles
    wr(30'h0, 32'h5);
    for (int i = 1; i <= 4; i++) wr(30'(i), 32'd4);
    wait_fin("clean");
    check("clean_err",   32'(error_num),     32'd0);
    check("clean_first", 32'(first_err_idx), 32'h3F);
    check("clean_to",    32'(timed_out),     32'd0);
    check("clean_dur",   32'(duration),      32'd9);

    // one bad slot plus ignored out-of-window, re-trigger and mid-check cfg writes
    do_reset();
    wr(30'h0, 32'h5);
    wr(30'h1, 32'd4);
    cfg(2'd0, 32'd9);
    wr(30'h2, 32'd4);
    wr(30'h5, 32'd9);
    wr(30'h0, 32'h5);
    wr(30'h3, 32'd7);
    wr(30'h4, 32'd4);
    wait_fin("bad");
    check("bad_err",   32'(error_num),     32'd1);
    check("bad_first", 32'(first_err_idx), 32'd2);
    check("bad_to",    32'(timed_out),     32'd0);

    // stalled write held five cycles counts once
    do_reset();
    wr(30'h0, 32'h5);
    @(negedge clk);
    addr = 30'h1; data = 32'd4; wen = 1'b1;
    repeat (5) @(negedge clk);
    wen = 1'b0;
    for (int i = 2; i <= 4; i++) wr(30'(i), 32'd4);
    wait_fin("stall");
    check("stall_err",   32'(error_num),     32'd0);
    check("stall_first", 32'(first_err_idx), 32'h3F);

    // duplicate correct write to slot 3
    do_reset();
    wr(30'h0, 32'h5);
    wr(30'h1, 32'd4);
    wr(30'h2, 32'd4);
    wr(30'h4, 32'd4);
    wr(30'h4, 32'd4);
    wr(30'h3, 32'd4);
    wait_fin("dup");
    check("dup_err",   32'(error_num),     32'd1);
    check("dup_first", 32'(first_err_idx), 32'h3F);

    // timeout with two slots unwritten
    do_reset();
    wr(30'h0, 32'h5);
    wr(30'h1, 32'd4);
    wr(30'h2, 32'd4);
    repeat (12) @(negedge clk);
    check("tmo_early", 32'(finish), 32'd0);
    wait_fin("tmo");
    check("tmo_to",    32'(timed_out), 32'd1);
    check("tmo_err",   32'(error_num), 32'd2);
    check("tmo_dur",   32'(duration),  32'd20);
    repeat (3) @(negedge clk);
    check("tmo_hold",  32'(error_num), 32'd2);

    // completing write lands exactly on the timeout cycle
    do_reset();
    wr(30'h0, 32'h5);
    wr(30'h1, 32'd4);
    wr(30'h2, 32'd4);
    wr(30'h3, 32'd4);
    repeat (12) @(negedge clk);
    wr(30'h4, 32'd4);
    wait_fin("tie");
    check("tie_to",  32'(timed_out), 32'd0);
    check("tie_err", 32'(error_num), 32'd0);
    check("tie_dur", 32'(duration),  32'd20);

    // wrong trigger data, then abort mid-check with reset
    do_reset();
    wr(30'h0, 32'h6);
    repeat (3) @(negedge clk);
    check("wtrig_err", 32'(error_num), 32'hFF);
    check("wtrig_dur", 32'(duration),  32'd0);
    check("wtrig_fin", 32'(finish),    32'd0);
    wr(30'h0, 32'h5);
    wr(30'h1, 32'd4);
    check("armed_err", 32'(error_num), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_err", 32'(error_num), 32'hFF);
    check("abort_dur", 32'(duration),  32'd0);
    check("abort_fin", 32'(finish),    32'd0);
    rst = 1'b1;
    wr(30'h2, 32'd4);
    check("abort_idle", 32'(error_num), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
